// File: rtl/trig_capture_buffer.sv
// Circular pre/post-trigger sample capture buffer with a chronological read port.
// Optional free-run timeout trigger: define OSCOPE_AUTO_TRIG_EN.
module trig_capture_buffer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned PRE_TRIG     = 1024,
  parameter int unsigned AUTO_TIMEOUT = 65536
) (
  input  logic              osc_clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_enable,
  input  logic              pi_graph_done,
  input  logic [ADDR_W-1:0] read_adr,
  output logic [DATA_W-1:0] read_data,
  output logic              full,
  output logic              armed,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              auto_trig
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(DEPTH - PRE_TRIG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFILL, S_ARMED, S_POST, S_FULL
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q, pre_cnt_q, post_cnt_q, trig_addr_q;
  logic [DATA_W-1:0]   prev_q, read_data_q;
  logic                full_q, armed_q, auto_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_en_d, cross_d, timeout_d;
  logic [ADDR_W-1:0]   phys_d;

  always_comb begin
    wr_en_d = !reset && !pi_graph_done && sample_valid &&
              (state_q == S_PREFILL || state_q == S_ARMED || state_q == S_POST);
    cross_d = trig_enable && (prev_q < trig_level) && (sample_data >= trig_level);
    phys_d  = trig_addr_q - PRE_A + read_adr;
  end

`ifdef OSCOPE_AUTO_TRIG_EN
  localparam int unsigned TO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  logic [TO_W-1:0] to_cnt_q;

  assign timeout_d = (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));

  // Held at zero outside ARMED, so it always starts fresh on entry.
  always_ff @(posedge osc_clk) begin
    if (reset || state_q != S_ARMED) to_cnt_q <= '0;
    else if (wr_en_d)                to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign timeout_d = 1'b0;
`endif

  always_ff @(posedge osc_clk) begin
    if (wr_en_d) mem[wr_ptr_q] <= sample_data;
  end

  always_ff @(posedge osc_clk) begin
    if (reset) read_data_q <= '0;
    else       read_data_q <= mem[phys_d];
  end

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      prev_q      <= '0;
      full_q      <= 1'b0;
      armed_q     <= 1'b0;
      auto_q      <= 1'b0;
    end else if (pi_graph_done && state_q != S_IDLE) begin
      state_q <= S_IDLE;
      full_q  <= 1'b0;
      armed_q <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q   <= S_PREFILL;
          wr_ptr_q  <= '0;
          pre_cnt_q <= '0;
        end
        S_PREFILL: if (sample_valid) begin
          wr_ptr_q  <= wr_ptr_q + 1'b1;
          pre_cnt_q <= pre_cnt_q + 1'b1;
          prev_q    <= sample_data;
          if (pre_cnt_q == PRE_LAST) begin
            state_q <= S_ARMED;
            armed_q <= 1'b1;
          end
        end
        S_ARMED: if (sample_valid) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          prev_q   <= sample_data;
          if (cross_d || timeout_d) begin
            trig_addr_q <= wr_ptr_q;
            post_cnt_q  <= POST_LOAD;
            auto_q      <= timeout_d && !cross_d;
            armed_q     <= 1'b0;
            if (POST_LOAD == '0) begin
              state_q <= S_FULL;
              full_q  <= 1'b1;
            end else begin
              state_q <= S_POST;
            end
          end
        end
        S_POST: if (sample_valid) begin
          wr_ptr_q   <= wr_ptr_q + 1'b1;
          prev_q     <= sample_data;
          post_cnt_q <= post_cnt_q - 1'b1;
          if (post_cnt_q == ADDR_W'(1)) begin
            state_q <= S_FULL;
            full_q  <= 1'b1;
          end
        end
        S_FULL:  ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data = read_data_q;
  assign full      = full_q;
  assign armed     = armed_q;
  assign trig_addr = trig_addr_q;
  assign auto_trig = auto_q;

endmodule

// File: tb/tb_trig_capture_buffer.sv
// Scoreboard bench for trig_capture_buffer: DEPTH=16 with PRE_TRIG=4 and PRE_TRIG=15.
module tb_trig_capture_buffer;

  logic       osc_clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = '0;
  logic [7:0] trig_level = 8'h80;
  logic       trig_enable = 1'b1;
  logic       pi_graph_done = 1'b0;
  logic [3:0] read_adr = '0;
  logic [7:0] read_data;
  logic       full, armed, auto_trig;
  logic [3:0] trig_addr;

  logic       sv2 = 1'b0, pd2 = 1'b0;
  logic [7:0] sd2 = '0;
  logic [3:0] ra2 = '0;
  logic [7:0] rd2;
  logic       full2, armed2, at2;
  logic [3:0] ta2;

  logic [7:0] hist[$];
  logic [7:0] hist2[$];
  logic [7:0] exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  trig_capture_buffer #(.DATA_W(8), .ADDR_W(4), .PRE_TRIG(4), .AUTO_TIMEOUT(32)) u_dut (
    .osc_clk(osc_clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_level(trig_level), .trig_enable(trig_enable), .pi_graph_done(pi_graph_done),
    .read_adr(read_adr), .read_data(read_data), .full(full), .armed(armed),
    .trig_addr(trig_addr), .auto_trig(auto_trig));

  trig_capture_buffer #(.DATA_W(8), .ADDR_W(4), .PRE_TRIG(15), .AUTO_TIMEOUT(32)) u_dut15 (
    .osc_clk(osc_clk), .reset(reset), .sample_valid(sv2), .sample_data(sd2),
    .trig_level(trig_level), .trig_enable(trig_enable), .pi_graph_done(pd2),
    .read_adr(ra2), .read_data(rd2), .full(full2), .armed(armed2),
    .trig_addr(ta2), .auto_trig(at2));

  always #5 osc_clk = ~osc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit keep);
    sample_valid = 1'b1;
    sample_data  = d;
    if (keep) hist.push_back(d);
    tick();
    sample_valid = 1'b0;
    tick();
  endtask

  task automatic send_ramp(input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) send(8'(k * 16), 1'b1);
  endtask

  task automatic send2(input logic [7:0] d);
    sv2 = 1'b1;
    sd2 = d;
    hist2.push_back(d);
    tick();
    sv2 = 1'b0;
    tick();
  endtask

  // Done pulse collides with a valid sample; the collided sample must be dropped.
  task automatic rearm();
    pi_graph_done = 1'b1;
    sample_valid  = 1'b1;
    sample_data   = 8'hAA;
    tick();
    pi_graph_done = 1'b0;
    sample_valid  = 1'b0;
    check("done_full", 32'(full), 32'd0);
    check("done_armed", 32'(armed), 32'd0);
    check("done_auto", 32'(auto_trig), 32'd0);
    tick();
    hist.delete();
  endtask

  task automatic read_win(input bit sel);
    for (int i = 0; i < 16; i++) begin
      if (sel) begin
        ra2 = 4'(i);
        exp_q.push_back(hist2[hist2.size() - 16 + i]);
      end else begin
        read_adr = 4'(i);
        exp_q.push_back(hist[hist.size() - 16 + i]);
      end
      tick();
      check($sformatf("%s[%0d]", sel ? "rd15" : "rd", i),
            sel ? 32'(rd2) : 32'(read_data), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_full", 32'(full), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_taddr", 32'(trig_addr), 32'd0);
    check("rst_auto", 32'(auto_trig), 32'd0);
    check("rst_rdata", 32'(read_data), 32'd0);
    reset = 1'b0;
    tick();

    // Basic ramp capture
    send_ramp(0, 3);
    check("t1_armed3", 32'(armed), 32'd0);
    send_ramp(3, 1);
    check("t1_armed4", 32'(armed), 32'd1);
    send_ramp(4, 4);
    check("t1_pre_full", 32'(full), 32'd0);
    send_ramp(8, 1);
    check("t1_taddr", 32'(trig_addr), 32'd8);
    check("t1_armed_trig", 32'(armed), 32'd0);
    send_ramp(9, 10);
    check("t1_full_early", 32'(full), 32'd0);
    send_ramp(19, 1);
    check("t1_full", 32'(full), 32'd1);
    check("t1_auto", 32'(auto_trig), 32'd0);
    read_win(1'b0);
    send(8'h55, 1'b0);
    read_win(1'b0);

    // Re-arm via done pulse, recapture
    rearm();
    send_ramp(0, 20);
    check("t4_full", 32'(full), 32'd1);
    check("t4_taddr", 32'(trig_addr), 32'd8);
    read_win(1'b0);

    // Trigger disabled across pointer wrap, then enabled
    rearm();
    trig_enable = 1'b0;
    send_ramp(0, 40);
    check("t2_full_dis", 32'(full), 32'd0);
    check("t2_armed_dis", 32'(armed), 32'd1);
    trig_enable = 1'b1;
    send_ramp(40, 1);
    check("t2_taddr", 32'(trig_addr), 32'd8);
    send_ramp(41, 10);
    check("t2_full_early", 32'(full), 32'd0);
    send_ramp(51, 1);
    check("t2_full", 32'(full), 32'd1);
    read_win(1'b0);

    // Constant level above threshold
    rearm();
    for (int i = 0; i < 4; i++) send(8'h90, 1'b1);
    check("t3_armed", 32'(armed), 32'd1);
`ifdef OSCOPE_AUTO_TRIG_EN
    for (int i = 0; i < 31; i++) send(8'h90, 1'b1);
    check("t3_no_trig", 32'(armed), 32'd1);
    send(8'h90, 1'b1);
    check("t3_taddr", 32'(trig_addr), 32'd3);
    check("t3_armed_off", 32'(armed), 32'd0);
    for (int i = 0; i < 11; i++) send(8'h90, 1'b1);
    check("t3_full", 32'(full), 32'd1);
    check("t3_auto", 32'(auto_trig), 32'd1);
    read_win(1'b0);
`else
    for (int i = 0; i < 40; i++) send(8'h90, 1'b1);
    check("t3_armed_hold", 32'(armed), 32'd1);
    check("t3_full", 32'(full), 32'd0);
    check("t3_auto", 32'(auto_trig), 32'd0);
`endif

    // Reset during POST
    rearm();
    send_ramp(0, 11);
    check("t5_taddr", 32'(trig_addr), 32'd8);
    check("t5_post", 32'(full), 32'd0);
    reset = 1'b1;
    tick();
    check("t5_full", 32'(full), 32'd0);
    check("t5_armed", 32'(armed), 32'd0);
    check("t5_rdata", 32'(read_data), 32'd0);
    check("t5_taddr_rst", 32'(trig_addr), 32'd0);
    reset = 1'b0;
    hist.delete();
    tick();
    send_ramp(0, 3);
    check("t5_armed3", 32'(armed), 32'd0);
    send_ramp(3, 1);
    check("t5_armed4", 32'(armed), 32'd1);
    send_ramp(4, 16);
    check("t5_refull", 32'(full), 32'd1);
    check("t5_retaddr", 32'(trig_addr), 32'd8);
    read_win(1'b0);

    // PRE_TRIG = DEPTH-1: trigger goes straight to FULL
    for (int k = 0; k < 14; k++) send2(8'(k * 8));
    check("t6_armed14", 32'(armed2), 32'd0);
    send2(8'h70);
    check("t6_armed15", 32'(armed2), 32'd1);
    check("t6_full_pre", 32'(full2), 32'd0);
    send2(8'h80);
    check("t6_full", 32'(full2), 32'd1);
    check("t6_taddr", 32'(ta2), 32'd15);
    check("t6_armed_off", 32'(armed2), 32'd0);
    read_win(1'b1);
    ra2 = 4'd15;
    tick();
    check("t6_trig_sample", 32'(rd2), 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
